// File: rtl/toggle_link_pkg.sv
// rtl/toggle_link_pkg.sv - shared defaults, pending-state encoding and counter limit for the toggle event link
package toggle_link_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_FULL    = 2'd2
    } evt_state_e;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchroniser for one asynchronous level, clears to 0
module bit_sync
    import toggle_link_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - recovers one event per tog_in level change and queues them in a saturating counter
module toggle_event_rx
    import toggle_link_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_pend,
    output logic             ovf
);

    localparam int               WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [CNT_W-1:0]  PEND_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0]  PEND_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PEND_NEAR = PEND_MAX - PEND_ONE;
    // With a 1-bit counter the first event fills it and the last pop empties it.
    localparam evt_state_e ST_UP_FROM_EMPTY = (PEND_MAX == PEND_ONE) ? ST_FULL : ST_PENDING;
    localparam evt_state_e ST_DN_FROM_FULL  = (PEND_MAX == PEND_ONE) ? ST_EMPTY : ST_PENDING;

    logic             sync_out;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic             prev_q, prev_d;
    evt_state_e       st_q, st_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             armed;
    logic             tog_edge;
    logic             pop;
    logic             ovf_set;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_tog_sync (
        .clk(clk),
        .rst(rst),
        .d  (tog_in),
        .q  (sync_out)
    );

    // prev tracks sync_out during warm-up too, so a level held across reset never looks like an edge.
    always_comb begin
        armed    = (warm_q == WARM_DONE);
        warm_d   = armed ? warm_q : warm_q + WARM_ONE;
        prev_d   = sync_out;
        tog_edge = armed & (sync_out ^ prev_q);
        pop      = evt_valid & evt_ready;
    end

    always_comb begin
        st_d    = st_q;
        pend_d  = pend_q;
        ovf_set = 1'b0;
        unique case (st_q)
            ST_EMPTY: begin
                if (tog_edge) begin
                    pend_d = PEND_ONE;
                    st_d   = ST_UP_FROM_EMPTY;
                end
            end
            ST_PENDING: begin
                if (tog_edge && !pop) begin
                    pend_d = pend_q + PEND_ONE;
                    if (pend_q == PEND_NEAR) st_d = ST_FULL;
                end else if (!tog_edge && pop) begin
                    pend_d = pend_q - PEND_ONE;
                    if (pend_q == PEND_ONE) st_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (tog_edge && !pop) begin
                    ovf_set = 1'b1;
                end else if (!tog_edge && pop) begin
                    pend_d = PEND_NEAR;
                    st_d   = ST_DN_FROM_FULL;
                end
            end
            default: begin
                st_d   = ST_EMPTY;
                pend_d = '0;
            end
        endcase
        ovf_d = ovf_set | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q <= '0;
            prev_q <= 1'b0;
            st_q   <= ST_EMPTY;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            warm_q <= warm_d;
            prev_q <= prev_d;
            st_q   <= st_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_valid = (pend_q != '0);
    assign evt_pend  = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - self-checking bench for toggle_event_rx (default and CNT_W=2 instances)
module tb_toggle_event_rx;

    localparam int S = 2;

    logic       clk;
    logic       rst;
    logic       tog_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       valid_a, valid_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;
    logic       ovf_a, ovf_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    toggle_event_rx dut (
        .clk(clk), .rst(rst), .tog_in(tog_in), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
        .evt_valid(valid_a), .evt_pend(pend_a), .ovf(ovf_a)
    );

    toggle_event_rx #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .tog_in(tog_in), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
        .evt_valid(valid_b), .evt_pend(pend_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a level change sampled at clock n becomes an event at clock n+S; changes seen at
    // clock 1 after release fall inside warm-up and never produce an event.
    int  n;
    bit  last_lvl;
    int  due[$];
    int  pend_m[2];
    bit  ovf_m[2];
    int  popped;

    always @(posedge clk or posedge rst) begin : model
        bit ev;
        bit pop;
        bit set;
        int mx;
        if (rst) begin
            n = 0;
            due.delete();
            pend_m = '{0, 0};
            ovf_m  = '{0, 0};
            popped = 0;
        end else begin
            n++;
            if (n >= 2 && tog_in != last_lvl) due.push_back(n + S);
            last_lvl = tog_in;
            ev = 1'b0;
            if (due.size() > 0 && due[0] == n) begin
                ev = 1'b1;
                void'(due.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                mx  = (i == 0) ? 15 : 3;
                pop = evt_ready && (pend_m[i] > 0);
                set = ev && !pop && (pend_m[i] == mx);
                if (ev && !pop && pend_m[i] < mx) pend_m[i]++;
                else if (!ev && pop) pend_m[i]--;
                ovf_m[i] = set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_m[i]);
                if (i == 0 && pop) popped++;
            end
        end
    end

    always @(negedge clk) begin
        chk("pend_a", int'(pend_a), pend_m[0]);
        chk("valid_a", int'(valid_a), int'(pend_m[0] != 0));
        chk("ovf_a", int'(ovf_a), int'(ovf_m[0]));
        chk("pend_b", int'(pend_b), pend_m[1]);
        chk("valid_b", int'(valid_b), int'(pend_m[1] != 0));
        chk("ovf_b", int'(ovf_b), int'(ovf_m[1]));
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        tog_in = lvl;
        tick(2);
        rst = 1'b0;
    endtask

    // Toggle so that the resulting event lands on the same clock that evt_ready is high.
    task automatic toggle_with_pop();
        tog_in = ~tog_in;
        tick(S);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    initial begin
        int spacing;
        rst = 1'b1;
        tog_in = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;
        tick(1);

        // 1: tog_in high across reset release
        do_reset(1'b1);
        tick(10);
        chk("t1_pend", int'(pend_a), 0);
        chk("t1_valid", int'(valid_a), 0);

        // 2: single toggle latency and one pop
        do_reset(1'b0);
        tick(6);
        tog_in = 1'b1;
        tick(1);
        chk("t2_pend_k", int'(pend_a), 0);
        tick(1);
        chk("t2_pend_k1", int'(pend_a), 0);
        tick(1);
        chk("t2_pend_k2", int'(pend_a), 1);
        chk("t2_valid_k2", int'(valid_a), 1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("t2_pend_pop", int'(pend_a), 0);
        chk("t2_valid_pop", int'(valid_a), 0);

        // 3: saturation on the 2-bit instance, then clear
        do_reset(1'b0);
        tick(6);
        for (int i = 0; i < 5; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
        tick(4);
        chk("t3_pend_b", int'(pend_b), 3);
        chk("t3_ovf_b", int'(ovf_b), 1);
        chk("t3_pend_a", int'(pend_a), 5);
        chk("t3_ovf_a", int'(ovf_a), 0);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", int'(ovf_b), 0);
        chk("t3_pend_keep", int'(pend_b), 3);

        // 4: edge coincident with pop, mid-range and at FULL
        do_reset(1'b0);
        tick(6);
        for (int i = 0; i < 2; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
        chk("t4_pend_pre", int'(pend_a), 2);
        toggle_with_pop();
        tick(3);
        chk("t4_pend_mid", int'(pend_a), 2);
        tog_in = ~tog_in;
        tick(4);
        chk("t4_pend_full", int'(pend_b), 3);
        toggle_with_pop();
        tick(3);
        chk("t4_full_hold", int'(pend_b), 3);
        chk("t4_full_noovf", int'(ovf_b), 0);
        // drop at FULL with clr_ovf in the same cycle: set wins
        tog_in = ~tog_in;
        tick(S);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t4_set_wins", int'(ovf_b), 1);

        // 5: reset mid-stream clears at once; toggle at release is ignored
        chk("t5_pend_pre", int'(pend_a), 4);
        rst = 1'b1;
        #1;
        chk("t5_pend_rst", int'(pend_a), 0);
        chk("t5_valid_rst", int'(valid_a), 0);
        chk("t5_ovf_rst", int'(ovf_b), 0);
        tick(1);
        rst = 1'b0;
        tog_in = ~tog_in;
        tick(10);
        chk("t5_warm_pend", int'(pend_a), 0);

        // 6: random spacing against random ready
        do_reset(1'b0);
        tick(6);
        for (int i = 0; i < 30; i++) begin
            tog_in = ~tog_in;
            spacing = $urandom_range(8, 4);
            for (int j = 0; j < spacing; j++) begin
                evt_ready = 1'($urandom_range(1, 0));
                tick(1);
            end
        end
        evt_ready = 1'b0;
        tick(6);
        chk("t6_conserve", popped + int'(pend_a), 30);
        chk("t6_no_ovf", int'(ovf_a), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
